regfile_write_arbiter: RTL and testbench

Arbitrates register-file writes from two requesters (A and B) onto the single Y/C write path of the down-sampling processor. Each requester has a one-entry buffer, and a round-robin grant selects one buffered write per cycle. The block drives the bank-select (`wr_swap`) and register-index (`wr_sel`) inputs of the one-hot write decoder, plus a one-cycle write strobe and the write data. It also counts same-target write collisions for debug.

---
 rtl/regfile_write_arbiter.sv | 86 ++++++++
 tb/tb_regfile_write_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter merging two buffered register-file write requesters onto one write path
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_bank,
  input  logic [2:0]        a_idx,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_bank,
  input  logic [2:0]        b_idx,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic              wr_swap,
  output logic [2:0]        wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [CNT_W-1:0]  coll_cnt,
  input  logic              coll_clr
);
  logic              a_full, b_full, a_bank_q, b_bank_q, last;
  logic [2:0]        a_idx_q, b_idx_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;
  logic              a_grant, b_grant, a_acc, b_acc, coll;
  always_comb begin
    a_grant = a_full && (!b_full || last);
    b_grant = b_full && (!a_full || !last);
    a_ready = !a_full || a_grant;
    b_ready = !b_full || b_grant;
    a_acc   = a_valid && a_ready;
    b_acc   = b_valid && b_ready;
    coll    = a_full && b_full && ({a_bank_q, a_idx_q} == {b_bank_q, b_idx_q});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_full   <= 1'b0;
      b_full   <= 1'b0;
      a_bank_q <= 1'b0;
      b_bank_q <= 1'b0;
      a_idx_q  <= '0;
      b_idx_q  <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      last     <= 1'b1;
      wr_en    <= 1'b0;
      wr_swap  <= 1'b0;
      wr_sel   <= '0;
      wr_data  <= '0;
      wr_src   <= 1'b0;
      coll_cnt <= '0;
    end else begin
      a_full <= a_acc ? 1'b1 : (a_grant ? 1'b0 : a_full);
      b_full <= b_acc ? 1'b1 : (b_grant ? 1'b0 : b_full);
      if (a_acc) begin
        a_bank_q <= a_bank;
        a_idx_q  <= a_idx;
        a_data_q <= a_data;
      end
      if (b_acc) begin
        b_bank_q <= b_bank;
        b_idx_q  <= b_idx;
        b_data_q <= b_data;
      end
      wr_en <= a_grant || b_grant;
      if (a_grant) begin
        wr_swap <= a_bank_q;
        wr_sel  <= a_idx_q;
        wr_data <= a_data_q;
        wr_src  <= 1'b0;
        last    <= 1'b0;
      end else if (b_grant) begin
        wr_swap <= b_bank_q;
        wr_sel  <= b_idx_q;
        wr_data <= b_data_q;
        wr_src  <= 1'b1;
        last    <= 1'b1;
      end
      coll_cnt <= coll_clr ? '0 : ((coll && coll_cnt != '1) ? coll_cnt + 1'b1 : coll_cnt);
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0, a_bank = 1'b0, b_valid = 1'b0, b_bank = 1'b0, coll_clr = 1'b0;
  logic [2:0] a_idx = '0, b_idx = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, wr_en, wr_swap, wr_src;
  logic [2:0] wr_sel;
  logic [7:0] wr_data, coll_cnt;
  int checks = 0;
  int failures = 0;
  regfile_write_arbiter #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_bank(a_bank), .a_idx(a_idx), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_bank(b_bank), .b_idx(b_idx), .b_data(b_data),
    .wr_en(wr_en), .wr_swap(wr_swap), .wr_sel(wr_sel), .wr_data(wr_data), .wr_src(wr_src),
    .coll_cnt(coll_cnt), .coll_clr(coll_clr)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask
  initial begin
    int na, nb, ns, bw;
    logic acc_a, acc_b;
    logic [7:0] qa[$], qb[$];
    logic [7:0] exp_d;
    step();
    step();
    reset = 1'b0;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_swap", wr_swap, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_src", wr_src, 0);
    chk("rst_coll_cnt", coll_cnt, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    a_valid = 1'b1; a_bank = 1'b1; a_idx = 3'd5; a_data = 8'h3C;
    step();
    a_valid = 1'b0;
    chk("single_lat_wr_en", wr_en, 0);
    step();
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_swap", wr_swap, 1);
    chk("single_wr_sel", wr_sel, 5);
    chk("single_wr_data", wr_data, 8'h3C);
    chk("single_wr_src", wr_src, 0);
    step();
    chk("single_after_wr_en", wr_en, 0);
    chk("single_hold_sel", wr_sel, 5);
    chk("single_hold_data", wr_data, 8'h3C);
    chk("single_hold_swap", wr_swap, 1);
    do_reset();
    na = 0; nb = 0; ns = 0;
    for (int c = 0; c < 12; c++) begin
      a_valid = (na < 4); b_valid = (nb < 4);
      a_data = 8'hA0 + 8'(na); b_data = 8'hB0 + 8'(nb);
      a_bank = 1'b0; b_bank = 1'b1; a_idx = 3'(na); b_idx = 3'(nb);
      if (c >= 1 && c <= 6) begin
        chk("rr_a_ready", a_ready, c % 2);
        chk("rr_b_ready", b_ready, (c + 1) % 2);
      end
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      step();
      na += int'(acc_a);
      nb += int'(acc_b);
      if (wr_en) begin
        exp_d = (ns % 2 == 1) ? 8'hB0 + 8'(ns / 2) : 8'hA0 + 8'(ns / 2);
        chk("rr_src", wr_src, ns % 2);
        chk("rr_data", wr_data, exp_d);
        ns++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("rr_strobes", ns, 8);
    for (int c = 0; c < 10; c++) begin
      a_valid = (c < 8); a_bank = 1'b0; a_idx = 3'(c); a_data = 8'h50 + 8'(c);
      if (c < 8) chk("stream_a_ready", a_ready, 1);
      step();
      if (c >= 1 && c <= 8) begin
        chk("stream_wr_en", wr_en, 1);
        chk("stream_wr_sel", wr_sel, c - 1);
        chk("stream_wr_data", wr_data, 8'h50 + c - 1);
      end else if (c == 9) chk("stream_end_wr_en", wr_en, 0);
    end
    do_reset();
    a_valid = 1'b1; a_bank = 1'b0; a_idx = 3'd2; a_data = 8'h11;
    b_valid = 1'b1; b_bank = 1'b0; b_idx = 3'd2; b_data = 8'h22;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("coll_pre", coll_cnt, 0);
    step();
    chk("coll_cnt1", coll_cnt, 1);
    chk("coll_first_en", wr_en, 1);
    chk("coll_first_data", wr_data, 8'h11);
    step();
    chk("coll_second_en", wr_en, 1);
    chk("coll_second_data", wr_data, 8'h22);
    chk("coll_second_src", wr_src, 1);
    chk("coll_cnt_once", coll_cnt, 1);
    step();
    chk("coll_done_en", wr_en, 0);
    a_valid = 1'b1; b_valid = 1'b1;
    for (int c = 0; c < 300; c++) step();
    chk("coll_sat", coll_cnt, 255);
    coll_clr = 1'b1;
    step();
    chk("coll_clr_priority", coll_cnt, 0);
    coll_clr = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();
    step();
    a_valid = 1'b1; a_bank = 1'b1; a_idx = 3'd3; a_data = 8'h77;
    b_valid = 1'b1; b_bank = 1'b1; b_idx = 3'd4; b_data = 8'h88;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_wr_sel", wr_sel, 0);
    chk("midrst_wr_swap", wr_swap, 0);
    chk("midrst_a_ready", a_ready, 1);
    chk("midrst_b_ready", b_ready, 1);
    step();
    chk("midrst_no_strobe", wr_en, 0);
    na = 0; nb = 0; bw = 0;
    for (int c = 0; c < 206; c++) begin
      b_valid = (c < 200);
      a_valid = (c < 200) && ($urandom_range(1) == 1);
      a_data = 8'(na); b_data = 8'h80 + 8'(nb);
      a_idx = 3'(na); b_idx = 3'(nb + 1);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      if (acc_a) begin qa.push_back(a_data); na++; end
      if (acc_b) begin qb.push_back(b_data); nb++; end
      step();
      if (wr_en) begin
        if (wr_src) begin
          chk("sb_b_nonempty", qb.size() > 0, 1);
          if (qb.size() > 0) chk("sb_b_data", wr_data, qb.pop_front());
        end else begin
          chk("sb_a_nonempty", qa.size() > 0, 1);
          if (qa.size() > 0) chk("sb_a_data", wr_data, qa.pop_front());
        end
      end
      bw = (wr_en && wr_src) ? 0 : ((qb.size() > 0) ? bw + 1 : 0);
      chk("sb_b_wait", bw <= 1, 1);
    end
    chk("sb_a_drained", qa.size(), 0);
    chk("sb_b_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
